// File: rtl/ht_cmd_arbiter_pkg.sv
// ht_cmd_arbiter_pkg: shared hash-table command type plus arbiter constants and state encoding.
package ht_cmd_arbiter_pkg;
   typedef enum logic [1:0] {HT_CMD_NOP, HT_CMD_INSERT, HT_CMD_LOOKUP, HT_CMD_DELETE} ht_command_t;
   localparam int HT_CMD_WIDTH = $bits(ht_command_t);
   localparam int HT_ARB_CNT_WIDTH = 16;
   typedef enum logic {ARB_EMPTY, ARB_FULL} ht_arb_state_t;
endpackage

// File: rtl/ht_cmd_arbiter_rr.sv
// rr_arbiter: round-robin priority encoder; search starts just above ptr and wraps.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int SW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [SW-1:0]      idx
);
   always_comb begin
      int c;
      c = 0;
      grant = '0;
      idx = '0;
      // walk from the farthest offset down so the nearest requester overwrites last
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         c = (int'(ptr) + 1 + i) % NUM_REQ;
         if (req[c]) begin
            grant = '0;
            grant[c] = 1'b1;
            idx = SW'(c);
         end
      end
   end
endmodule

// File: rtl/ht_cmd_arbiter.sv
// ht_cmd_arbiter: round-robin share of one hash-table command pipeline with a registered output stage.
// Define HT_ARB_STATS_EN for saturating per-requester accepted-command counters.
module ht_cmd_arbiter
   import ht_cmd_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int KEY_WIDTH = 32,
   parameter int VALUE_WIDTH = 16,
   localparam int SRC_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_n_i,
   input  logic [NUM_REQ-1:0]                    req_valid_i,
   output logic [NUM_REQ-1:0]                    req_ready_o,
   input  logic [NUM_REQ*KEY_WIDTH-1:0]          req_key_i,
   input  logic [NUM_REQ*VALUE_WIDTH-1:0]        req_value_i,
   input  logic [NUM_REQ*HT_CMD_WIDTH-1:0]       req_cmd_i,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output logic [KEY_WIDTH-1:0]                  out_key_o,
   output logic [VALUE_WIDTH-1:0]                out_value_o,
   output logic [HT_CMD_WIDTH-1:0]               out_cmd_o,
   output logic [SRC_WIDTH-1:0]                  out_src_o,
   output logic [NUM_REQ*HT_ARB_CNT_WIDTH-1:0]   stat_cnt_o
);
   ht_arb_state_t state;
   logic [SRC_WIDTH-1:0] rr_ptr, win;
   logic [NUM_REQ-1:0] grant;
   logic load;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (req_valid_i),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win)
   );

   assign load = ((state == ARB_EMPTY) | out_ready_i) & (|req_valid_i);
   assign req_ready_o = load ? grant : '0;
   assign out_valid_o = (state == ARB_FULL);

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state <= ARB_EMPTY;
         rr_ptr <= SRC_WIDTH'(NUM_REQ - 1);
         out_key_o <= '0;
         out_value_o <= '0;
         out_cmd_o <= '0;
         out_src_o <= '0;
      end else if (load) begin
         state <= ARB_FULL;
         rr_ptr <= win;
         out_key_o <= req_key_i[win*KEY_WIDTH +: KEY_WIDTH];
         out_value_o <= req_value_i[win*VALUE_WIDTH +: VALUE_WIDTH];
         out_cmd_o <= req_cmd_i[win*HT_CMD_WIDTH +: HT_CMD_WIDTH];
         out_src_o <= win;
      end else if (out_ready_i)
         state <= ARB_EMPTY;

`ifdef HT_ARB_STATS_EN
   logic [NUM_REQ-1:0][HT_ARB_CNT_WIDTH-1:0] cnt;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i)
         cnt <= '0;
      else if (load && cnt[win] != '1)
         cnt[win] <= cnt[win] + 1'b1;
   assign stat_cnt_o = cnt;
`else
   assign stat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// tb_ht_cmd_arbiter: directed vectors with hand-computed expectations for ht_cmd_arbiter.
module tb_ht_cmd_arbiter;
   import ht_cmd_arbiter_pkg::*;
   localparam int N = 4;
   localparam int KW = 32;
   localparam int VW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_ready;
   logic [N*KW-1:0] req_key = '0;
   logic [N*VW-1:0] req_value = '0;
   logic [N*HT_CMD_WIDTH-1:0] req_cmd = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [KW-1:0] out_key;
   logic [VW-1:0] out_value;
   logic [HT_CMD_WIDTH-1:0] out_cmd;
   logic [1:0] out_src;
   logic [N*16-1:0] stat_cnt;
   int n_cmp = 0;
   int n_err = 0;

   ht_cmd_arbiter #(.NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_key_i   (req_key),
      .req_value_i (req_value),
      .req_cmd_i   (req_cmd),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_key_o   (out_key),
      .out_value_o (out_value),
      .out_cmd_o   (out_cmd),
      .out_src_o   (out_src),
      .stat_cnt_o  (stat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [KW-1:0] k, input logic [VW-1:0] v, input logic [1:0] c);
      req_key[r*KW +: KW] = k;
      req_value[r*VW +: VW] = v;
      req_cmd[r*HT_CMD_WIDTH +: HT_CMD_WIDTH] = c;
   endtask

   initial begin
      logic [63:0] exp_stat;
      #2;
      check("rst_valid", 64'(out_valid), 0);
      check("rst_key", 64'(out_key), 0);
      check("rst_src", 64'(out_src), 0);
      check("rst_stat", stat_cnt, 0);
      #20 rst_n = 1'b1;
      repeat (10) begin
         tick();
         check("idle_valid", 64'(out_valid), 0);
         check("idle_ready", 64'(req_ready), 0);
         check("idle_stat", stat_cnt, 0);
      end
      // all four requesters valid: grants must cycle 0,1,2,3,0
      for (int r = 0; r < N; r++) set_req(r, KW'(32'h10 + r), VW'(16'h100 + r), 2'(r));
      req_valid = 4'b1111;
      out_ready = 1'b1;
      #1 check("rr_ready0", 64'(req_ready), 64'b0001);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_valid", 64'(out_valid), 1);
         check("rr_src", 64'(out_src), 64'(k % 4));
         check("rr_key", 64'(out_key), 64'(32'h10 + k % 4));
         check("rr_value", 64'(out_value), 64'(16'h100 + k % 4));
         check("rr_ready", 64'(req_ready), 64'(1 << ((k + 1) % 4)));
      end
`ifdef HT_ARB_STATS_EN
      exp_stat = 64'h0001_0001_0001_0002;
`else
      exp_stat = 64'h0;
`endif
      check("rr_stat", stat_cnt, exp_stat);
      req_valid = '0;
      tick();
      check("drain_valid", 64'(out_valid), 0);
      // backpressure on a single requester
      set_req(2, 32'hDEAD_BEEF, 16'hBEEF, HT_CMD_LOOKUP);
      req_valid = 4'b0100;
      out_ready = 1'b0;
      #1 check("bp_ready_empty", 64'(req_ready), 64'b0100);
      tick();
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 64'(out_valid), 1);
         check("bp_key", 64'(out_key), 64'h0000_0000_DEAD_BEEF);
         check("bp_cmd", 64'(out_cmd), 64'(HT_CMD_LOOKUP));
         check("bp_src", 64'(out_src), 2);
         check("bp_ready", 64'(req_ready), 0);
         tick();
      end
      // leave rr_ptr at 1, then stall with requesters 0 and 3 waiting
      req_valid = '0;
      out_ready = 1'b1;
      tick();
      check("bp_drain", 64'(out_valid), 0);
      req_valid = 4'b0010;
      tick();
      check("ptr1_src", 64'(out_src), 1);
      out_ready = 1'b0;
      set_req(0, 32'hA0, 16'h0, HT_CMD_INSERT);
      set_req(3, 32'hA3, 16'h0, HT_CMD_DELETE);
      req_valid = 4'b1001;
      repeat (2) begin
         tick();
         check("stall_ready", 64'(req_ready), 0);
         check("stall_src", 64'(out_src), 1);
      end
      out_ready = 1'b1;
      #1 check("fair_ready3", 64'(req_ready), 64'b1000);
      tick();
      check("fair_src3", 64'(out_src), 3);
      check("fair_key3", 64'(out_key), 64'hA3);
      req_valid = 4'b0001;
      #1 check("fair_ready0", 64'(req_ready), 64'b0001);
      tick();
      check("fair_src0", 64'(out_src), 0);
      check("fair_key0", 64'(out_key), 64'hA0);
      // asynchronous reset while holding a command
      req_valid = 4'b0100;
      out_ready = 1'b0;
      tick();
      check("pre_rst_valid", 64'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1 check("arst_valid", 64'(out_valid), 0);
      check("arst_key", 64'(out_key), 0);
      check("arst_src", 64'(out_src), 0);
      #2 rst_n = 1'b1;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      #1 check("post_rst_ready", 64'(req_ready), 64'b0001);
      tick();
      check("post_rst_src", 64'(out_src), 0);
`ifdef HT_ARB_STATS_EN
      check("post_rst_stat", stat_cnt, 64'h0000_0000_0000_0001);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      req_valid = 4'b0010;
      repeat (70000) tick();
      check("sat_stat", stat_cnt, 64'h0000_0000_FFFF_0000);
`else
      check("post_rst_stat", stat_cnt, 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
